// File: rtl/cpu_pkg.sv
// cpu_pkg: shared write-back select codes, register-zero index and datapath width defaults.
package cpu_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef enum logic [1:0] {
        MEMTOREG_ALU = 2'b00,
        MEMTOREG_MEM = 2'b01,
        MEMTOREG_PC4 = 2'b10
    } memtoreg_e;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: combinational write-back source select; the reserved code 2'b11 falls back to the ALU result.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        mem_to_reg,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] wb_data
);
    always_comb begin
        wb_data = (mem_to_reg == MEMTOREG_MEM) ? mem_data :
                  (mem_to_reg == MEMTOREG_PC4) ? pc_plus4 : alu_out;
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32-entry register file with two async read ports and a commit counter.
// Define REGFILE_BYPASS_EN to make reads return the same-cycle write-back value (write-first).
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_WB_RegWrite,
    input  logic [1:0]        MEM_WB_MemtoReg,
    input  logic [DATA_W-1:0] MEM_WB_PCplus4,
    input  logic [DATA_W-1:0] MEM_WB_ALUout,
    input  logic [ADDR_W-1:0] MEM_WB_RegWriteAddr,
    input  logic [DATA_W-1:0] MEM_WB_MemReadData,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic              WB_WriteEn,
    output logic [CNT_W-1:0]  wb_count
);
    localparam int N = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [N];
    logic [DATA_W-1:0] regs_d [N];
    logic [CNT_W-1:0]  wb_count_q, wb_count_d;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .mem_to_reg (MEM_WB_MemtoReg),
        .alu_out    (MEM_WB_ALUout),
        .mem_data   (MEM_WB_MemReadData),
        .pc_plus4   (MEM_WB_PCplus4),
        .wb_data    (WB_WriteData)
    );

    assign WB_WriteEn = MEM_WB_RegWrite && (MEM_WB_RegWriteAddr != ZERO);
    assign wb_count   = wb_count_q;

    // Reset dominates a concurrent write; entry 0 is never written so reads of it are forced below.
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (reset) begin
            regs_d     = '{default: '0};
            wb_count_d = '0;
        end else if (WB_WriteEn) begin
            regs_d[MEM_WB_RegWriteAddr] = WB_WriteData;
            wb_count_d                  = wb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        regs_q     <= regs_d;
        wb_count_q <= wb_count_d;
    end

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rs_data = (rs_addr == ZERO) ? '0 :
                  (WB_WriteEn && rs_addr == MEM_WB_RegWriteAddr) ? WB_WriteData : regs_q[rs_addr];
        rt_data = (rt_addr == ZERO) ? '0 :
                  (WB_WriteEn && rt_addr == MEM_WB_RegWriteAddr) ? WB_WriteData : regs_q[rt_addr];
`else
        rs_data = (rs_addr == ZERO) ? '0 : regs_q[rs_addr];
        rt_data = (rt_addr == ZERO) ? '0 : regs_q[rt_addr];
`endif
    end
endmodule
